// File: rtl/wave_capture_mc.sv
// Multi-channel triggered waveform capture into a double-buffered RAM.
// Optional timeout auto-trigger is enabled with `define WAVE_CAPTURE_AUTOTRIG_EN.
module wave_capture_mc #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int DEPTH    = 9
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 1024
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_sample,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [1:0]                 trig_ch,
  input  logic [1:0]                 trig_mode,
  input  logic                       display_idle,
  output logic [DEPTH-1:0]           write_address,
  output logic [NUM_CH-1:0]          write_enable,
  output logic [NUM_CH*OUT_W-1:0]    write_sample,
  output logic                       read_index,
  output logic                       capture_done,
  output logic                       auto_trig
);

  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  state_t                    r_state;
  logic [DEPTH-2:0]          r_index;
  logic                      r_prev_msb;
  logic                      r_read_index;
  logic                      r_capture_done;
  logic                      r_auto_trig;
  logic [DEPTH-1:0]          r_write_address;
  logic [NUM_CH-1:0]         r_write_enable;
  logic [NUM_CH*OUT_W-1:0]   r_write_sample;

  logic [NUM_CH*OUT_W-1:0]   w_wsample;
  logic                      w_cur_msb;
  logic                      w_real_trig;
  logic                      w_force;
  logic                      w_trig;
  logic                      w_unused;

  // Keep the top OUT_W bits and flip the sign bit: two's complement -> offset binary.
  function automatic logic [OUT_W-1:0] to_offset(input logic signed [SAMPLE_W-1:0] s);
    logic [OUT_W-1:0] t;
    t = s[SAMPLE_W-1 -: OUT_W];
    t[OUT_W-1] = ~t[OUT_W-1];
    return t;
  endfunction

  // Out-of-range trig_ch falls back to channel 0 via the default.
  always_comb begin
    w_wsample = '0;
    w_cur_msb = sample[SAMPLE_W-1];
    for (int c = 0; c < NUM_CH; c++) begin
      w_wsample[c*OUT_W +: OUT_W] = to_offset(sample[c*SAMPLE_W +: SAMPLE_W]);
      if (trig_ch == 2'(c)) w_cur_msb = sample[c*SAMPLE_W + SAMPLE_W - 1];
    end
  end

  always_comb begin
    w_real_trig = 1'b0;
    if (new_sample) begin
      case (trig_mode)
        2'b01:   w_real_trig = r_prev_msb & ~w_cur_msb;
        2'b10:   w_real_trig = ~r_prev_msb & w_cur_msb;
        default: w_real_trig = 1'b1;
      endcase
    end
  end

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  localparam logic [15:0] TO_LIM = 16'(AUTO_TIMEOUT);
  logic [15:0] r_to_cnt;
  assign w_force = new_sample & (r_to_cnt == TO_LIM);
`else
  assign w_force = 1'b0;
`endif

  assign w_trig   = (r_state == ARMED) & (w_real_trig | w_force);
  assign w_unused = ^sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ARMED;
      r_index         <= '0;
      r_prev_msb      <= 1'b0;
      r_read_index    <= 1'b0;
      r_capture_done  <= 1'b0;
      r_auto_trig     <= 1'b0;
      r_write_address <= '0;
      r_write_enable  <= '0;
      r_write_sample  <= '0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
      r_to_cnt        <= '0;
`endif
    end else begin
      r_write_enable <= '0;
      r_capture_done <= 1'b0;
      if (new_sample) r_prev_msb <= w_cur_msb;
      case (r_state)
        ARMED: begin
          if (w_trig) begin
            r_write_enable  <= ch_enable;
            r_write_address <= {~r_read_index, {(DEPTH-1){1'b0}}};
            r_write_sample  <= w_wsample;
            r_index         <= {{(DEPTH-2){1'b0}}, 1'b1};
            r_auto_trig     <= ~w_real_trig;
            r_state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (new_sample) begin
            r_write_enable  <= ch_enable;
            r_write_address <= {~r_read_index, r_index};
            r_write_sample  <= w_wsample;
            r_index         <= r_index + 1'b1;
            if (r_index == '1) r_state <= WAIT;
          end
        end
        WAIT: begin
          // Swap halves; a coincident strobe is intentionally dropped.
          if (display_idle) begin
            r_read_index   <= ~r_read_index;
            r_capture_done <= 1'b1;
            r_state        <= ARMED;
          end
        end
        default: r_state <= ARMED;
      endcase
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
      if (r_state != ARMED || w_trig) r_to_cnt <= '0;
      else if (new_sample)            r_to_cnt <= r_to_cnt + 1'b1;
`endif
    end
  end

  assign write_address = r_write_address;
  assign write_enable  = r_write_enable;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;
  assign capture_done  = r_capture_done;
  assign auto_trig     = r_auto_trig;

endmodule

// File: doc/wave_capture_mc.md
WAVE_CAPTURE_MC -- requirements
Module: wave_capture_mc

Interface
REQ-001 Parameter NUM_CH, default 2, number of captured channels (1..4).
REQ-002 Parameter SAMPLE_W, default 16, signed input sample width per channel.
REQ-003 Parameter OUT_W, default 8, stored sample width per channel.
REQ-004 Parameter DEPTH, default 9, RAM address width; MSB selects the half, so 2^(DEPTH-1) samples are captured per frame.
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 new_sample  in  1  one-cycle strobe qualifying sample.
REQ-008 sample  in  NUM_CH*SAMPLE_W  packed signed samples, channel 0 in LSBs.
REQ-009 ch_enable  in  NUM_CH  per-channel write enable mask.
REQ-010 trig_ch  in  2  trigger source channel.
REQ-011 trig_mode  in  2  00 free-run, 01 rising zero-cross, 10 falling zero-cross, 11 free-run.
REQ-012 display_idle  in  1  high while the display is not reading the RAM.
REQ-013 write_address  out  DEPTH  shared RAM write address.
REQ-014 write_enable  out  NUM_CH  per-channel RAM write strobe.
REQ-015 write_sample  out  NUM_CH*OUT_W  packed offset-binary samples.
REQ-016 read_index  out  1  half the display reads.
REQ-017 capture_done  out  1  one-cycle pulse on buffer swap.
REQ-018 auto_trig  out  1  high when the current frame was started by timeout.

Function
REQ-019 FSM states: ARMED, ACTIVE, WAIT.
- ARMED -> ACTIVE on the trigger sample.
- ACTIVE -> WAIT after the 2^(DEPTH-1)th write.
- WAIT -> ARMED when display_idle is high.
REQ-020 The previous-sample register for the trig_ch channel updates on every new_sample in all states.
REQ-021 Trigger conditions:
- Rising: previous MSB=1 and current MSB=0.
- Falling: previous MSB=0 and current MSB=1.
- Free-run: any new_sample in ARMED.
REQ-022 trig_ch >= NUM_CH selects channel 0.
REQ-023 The trigger sample is written at index 0; subsequent new_sample strobes in ACTIVE write indices 1..2^(DEPTH-1)-1.
REQ-024 write_enable, write_address and write_sample are registered and valid exactly one cycle after the qualifying new_sample.
REQ-025 write_address = {~read_index, index[DEPTH-2:0]}.
REQ-026 write_sample per channel = sample[SAMPLE_W-1 -: OUT_W] with the MSB inverted (signed to offset binary).
REQ-027 A write_enable bit for a channel is 0 when its ch_enable bit is 0; the index still advances.
REQ-028 new_sample in WAIT is discarded; no writes occur in ARMED except the trigger sample.
REQ-029 On the WAIT->ARMED transition:
- read_index toggles.
- capture_done pulses for exactly one cycle.
REQ-030 If new_sample coincides with the WAIT->ARMED swap, that sample is discarded and cannot trigger.
REQ-031 display_idle is ignored outside WAIT.
REQ-032 trig_mode and trig_ch are sampled only in ARMED; changes during ACTIVE do not affect the frame.

Reset
REQ-033 While reset is low, the block asynchronously forces the following, and they hold until reset rises:
- State = ARMED.
- read_index, capture_done, auto_trig, write_enable, write_address, write_sample = 0.
- Index, previous sample and timeout counter = 0.
REQ-034 Reset mid-ACTIVE abandons the partial frame; the next frame restarts at index 0 in half 1.

Configuration
REQ-035 Macro WAVE_CAPTURE_AUTOTRIG_EN.
- Defined:
  - A 16-bit counter counts new_sample strobes in ARMED and clears on leaving ARMED.
  - On reaching parameter AUTO_TIMEOUT (default 1024), the next new_sample is forced as the trigger.
  - auto_trig is set for that frame and cleared at the next ARMED->ACTIVE via a real trigger.
- Undefined: no counter; ARMED waits indefinitely; auto_trig is tied 0.

Verification
REQ-036 NUM_CH=2, DEPTH=9, trig_mode=01, ch0 ramps -8..+8 step 1 per strobe -> the first write occurs at the sample 0x0000 strobe, index 0, write_sample ch0=0x80, write_address=0x100.
REQ-037 Free-run, 256 strobes, then display_idle=1 -> address runs 0x100..0x1FF, capture_done pulses once, read_index=1; the next frame writes 0x000..0x0FF.
REQ-038 ch_enable=2'b01 -> write_enable[1] stays 0 through the whole frame; write_enable[0] pulses 256 times.
REQ-039 new_sample on the same cycle as the display_idle swap -> no write, no trigger; the trigger occurs on the following qualifying strobe.
REQ-040 reset low at index 100 of a frame -> all outputs 0 immediately.
REQ-041 With WAVE_CAPTURE_AUTOTRIG_EN, trig_mode=01 and constant input 0x1000 -> the trigger occurs on strobe 1025 with auto_trig=1; without the macro, no write occurs after 5000 strobes.
